// File: rtl/coin_pkg.sv
// Shared definitions for the coin tally: FSM encoding, default coin values,
// saturation ceiling and the step/hold option codes produced by the debouncers.
package coin_pkg;

  typedef enum logic [1:0] {
    S_IDLE         = 2'd0,
    S_WAIT_RELEASE = 2'd1,
    S_HOLD         = 2'd2
  } tally_state_e;

  localparam int COIN_VAL_U    = 1;
  localparam int COIN_VAL_L    = 5;
  localparam int COIN_VAL_R    = 10;
  localparam int COIN_VAL_D    = 25;
  localparam int MAX_TOTAL_DEF = 999;
  localparam int TOTAL_W_DEF   = 10;

  localparam logic [3:0] STEP_NONE = 4'b0000;
  localparam logic [3:0] STEP_U    = 4'b0001;
  localparam logic [3:0] STEP_L    = 4'b0010;
  localparam logic [3:0] STEP_R    = 4'b0100;
  localparam logic [3:0] STEP_D    = 4'b1000;

  localparam logic [2:0] HOLD_RUN    = 3'b000;
  localparam logic [2:0] HOLD_FREEZE = 3'b001;
  localparam logic [2:0] HOLD_CLEAR  = 3'b010;

  // Clear dominates freeze; any code with bit1 set clears.
  function automatic logic hold_is_clear(input logic [2:0] code);
    return code[1];
  endfunction

  function automatic logic hold_is_freeze(input logic [2:0] code);
    return !code[1] && code[0];
  endfunction

endpackage

// File: rtl/coin_tally_bin_to_bcd.sv
// Combinational binary-to-BCD conversion of the tally into three decimal digits.
module bin_to_bcd #(
  parameter int TOTAL_W = 10
) (
  input  logic [TOTAL_W-1:0] bin_i,
  output logic [3:0]         hundreds_o,
  output logic [3:0]         tens_o,
  output logic [3:0]         ones_o
);

  logic [31:0] val;

  always_comb begin
    val        = 32'(bin_i);
    hundreds_o = 4'((val / 32'd100) % 32'd10);
    tens_o     = 4'((val / 32'd10) % 32'd10);
    ones_o     = 4'(val % 32'd10);
  end

endmodule

// File: rtl/coin_tally.sv
// Coin credit accumulator: one credit per button press, saturating at MAX_TOTAL,
// with freeze/clear hold modes and BCD display digits of the running total.
module coin_tally
  import coin_pkg::*;
#(
  parameter int VAL_U     = COIN_VAL_U,
  parameter int VAL_L     = COIN_VAL_L,
  parameter int VAL_R     = COIN_VAL_R,
  parameter int VAL_D     = COIN_VAL_D,
  parameter int MAX_TOTAL = MAX_TOTAL_DEF,
  parameter int TOTAL_W   = TOTAL_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         step_option,
  input  logic [2:0]         hold_option,
  output logic [TOTAL_W-1:0] total,
  output logic [3:0]         bcd_hundreds,
  output logic [3:0]         bcd_tens,
  output logic [3:0]         bcd_ones,
  output logic               add_pulse,
  output logic               sat
);

  localparam int SUM_W = TOTAL_W + 6;

  tally_state_e       state_q, state_d;
  logic [TOTAL_W-1:0] total_q, total_d;
  logic               sat_q, sat_d;
  logic               add_pulse_q, add_pulse_d;
  logic [SUM_W-1:0]   sum;
  logic               over;

  // Lowest set bit wins so a multi-bit code still credits a single coin.
  function automatic logic [SUM_W-1:0] coin_value(input logic [3:0] code);
    if (code[0])      return SUM_W'(VAL_U);
    else if (code[1]) return SUM_W'(VAL_L);
    else if (code[2]) return SUM_W'(VAL_R);
    else if (code[3]) return SUM_W'(VAL_D);
    else              return '0;
  endfunction

  function automatic logic exceeds_max(input logic [SUM_W-1:0] s);
    return s > SUM_W'(MAX_TOTAL);
  endfunction

  always_comb begin
    sum  = SUM_W'(total_q) + coin_value(step_option);
    over = exceeds_max(sum);
  end

  always_comb begin
    state_d     = state_q;
    total_d     = total_q;
    sat_d       = sat_q;
    add_pulse_d = 1'b0;
    if (hold_is_clear(hold_option)) begin
      state_d = S_HOLD;
      total_d = '0;
      sat_d   = 1'b0;
    end else if (hold_is_freeze(hold_option)) begin
      state_d = S_HOLD;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (step_option != STEP_NONE) begin
            state_d     = S_WAIT_RELEASE;
            add_pulse_d = 1'b1;
            if (over) begin
              total_d = TOTAL_W'(MAX_TOTAL);
              sat_d   = 1'b1;
            end else begin
              total_d = sum[TOTAL_W-1:0];
            end
          end
        end
        S_WAIT_RELEASE: begin
          if (step_option == STEP_NONE) state_d = S_IDLE;
        end
        S_HOLD: begin
          // Leaving hold with a button down must not credit that press.
          if (step_option == STEP_NONE) state_d = S_IDLE;
          else                          state_d = S_WAIT_RELEASE;
        end
        default: state_d = S_HOLD;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_HOLD;
      total_q     <= '0;
      sat_q       <= 1'b0;
      add_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      total_q     <= total_d;
      sat_q       <= sat_d;
      add_pulse_q <= add_pulse_d;
    end
  end

  assign total     = total_q;
  assign sat       = sat_q;
  assign add_pulse = add_pulse_q;

  bin_to_bcd #(
    .TOTAL_W (TOTAL_W)
  ) u_bcd (
    .bin_i      (total_q),
    .hundreds_o (bcd_hundreds),
    .tens_o     (bcd_tens),
    .ones_o     (bcd_ones)
  );

endmodule

// File: tb/tb_coin_tally.sv
// Directed bench for coin_tally: a default instance plus a small-ceiling instance.
module tb_coin_tally;

  logic       clk = 1'b0;
  logic       rst, rst2;
  logic [3:0] step_option, step2;
  logic [2:0] hold_option, hold2;
  logic [9:0] total;
  logic [5:0] total2;
  logic [3:0] bh, bt, bo, bh2, bt2, bo2;
  logic       add_pulse, add_pulse2, sat, sat2;

  int vectors = 0;
  int fails   = 0;
  int pulses  = 0;
  int pulses2 = 0;

  always #5 clk = ~clk;

  coin_tally dut (
    .clk(clk), .rst(rst), .step_option(step_option), .hold_option(hold_option),
    .total(total), .bcd_hundreds(bh), .bcd_tens(bt), .bcd_ones(bo),
    .add_pulse(add_pulse), .sat(sat)
  );

  coin_tally #(.MAX_TOTAL(40), .TOTAL_W(6)) dut2 (
    .clk(clk), .rst(rst2), .step_option(step2), .hold_option(hold2),
    .total(total2), .bcd_hundreds(bh2), .bcd_tens(bt2), .bcd_ones(bo2),
    .add_pulse(add_pulse2), .sat(sat2)
  );

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (add_pulse)  pulses++;
      if (add_pulse2) pulses2++;
    end
  endtask

  task automatic press(input logic [3:0] code);
    step_option = code;
    tick(1);
    step_option = 4'b0000;
    tick(1);
  endtask

  task automatic press2(input logic [3:0] code);
    step2 = code;
    tick(1);
    step2 = 4'b0000;
    tick(1);
  endtask

  task automatic clear_main();
    hold_option = 3'b010;
    step_option = 4'b0000;
    tick(1);
    hold_option = 3'b000;
    tick(1);
  endtask

  task automatic test_reset();
    rst = 1'b1; step_option = 4'b0000; hold_option = 3'b000;
    tick(2);
    vectors++;
    if (total !== 10'd0) begin fails++; $display("FAIL reset_total got=%0d exp=0", total); end
    vectors++;
    if (sat !== 1'b0 || add_pulse !== 1'b0) begin
      fails++; $display("FAIL reset_flags got sat=%b pulse=%b exp 0/0", sat, add_pulse);
    end
    rst = 1'b0;
    tick(1);
  endtask

  task automatic test_single();
    pulses = 0;
    step_option = 4'b0001;
    tick(1);
    vectors++;
    if (total !== 10'd1 || add_pulse !== 1'b1) begin
      fails++; $display("FAIL single_latency got total=%0d pulse=%b exp 1/1", total, add_pulse);
    end
    tick(1);
    vectors++;
    if (add_pulse !== 1'b0) begin fails++; $display("FAIL single_pulse_width got=%b exp=0", add_pulse); end
    tick(3);
    step_option = 4'b0000;
    tick(2);
    vectors++;
    if (total !== 10'd1 || bo !== 4'd1) begin
      fails++; $display("FAIL single_total got total=%0d ones=%0d exp 1/1", total, bo);
    end
    vectors++;
    if (pulses !== 1) begin fails++; $display("FAIL single_pulses got=%0d exp=1", pulses); end
  endtask

  task automatic test_sequence();
    clear_main();
    pulses = 0;
    press(4'b0010); press(4'b0100); press(4'b1000); press(4'b1000);
    vectors++;
    if (total !== 10'd65) begin fails++; $display("FAIL seq_total got=%0d exp=65", total); end
    vectors++;
    if ({bh, bt, bo} !== 12'h065) begin
      fails++; $display("FAIL seq_bcd got=%0d%0d%0d exp=065", bh, bt, bo);
    end
    vectors++;
    if (pulses !== 4 || sat !== 1'b0) begin
      fails++; $display("FAIL seq_pulses_sat got pulses=%0d sat=%b exp 4/0", pulses, sat);
    end
  endtask

  task automatic test_priority();
    clear_main();
    pulses = 0;
    press(4'b1100);
    press(4'b1111);
    press(4'b0110);
    vectors++;
    if (total !== 10'd16 || pulses !== 3) begin
      fails++; $display("FAIL priority got total=%0d pulses=%0d exp 16/3", total, pulses);
    end
  endtask

  task automatic test_back_to_back();
    clear_main();
    pulses = 0;
    step_option = 4'b1000; tick(2);
    step_option = 4'b0001; tick(2);
    step_option = 4'b0100; tick(2);
    step_option = 4'b0000; tick(1);
    vectors++;
    if (total !== 10'd25 || pulses !== 1) begin
      fails++; $display("FAIL held_code_change got total=%0d pulses=%0d exp 25/1", total, pulses);
    end
    step_option = 4'b0010; tick(1);
    step_option = 4'b0000; tick(1);
    step_option = 4'b0010; tick(1);
    step_option = 4'b0000; tick(1);
    vectors++;
    if (total !== 10'd35 || pulses !== 3) begin
      fails++; $display("FAIL back_to_back got total=%0d pulses=%0d exp 35/3", total, pulses);
    end
  endtask

  task automatic test_saturation();
    clear_main();
    for (int i = 0; i < 39; i++) press(4'b1000);
    press(4'b0100);
    press(4'b0010);
    vectors++;
    if (total !== 10'd990 || sat !== 1'b0) begin
      fails++; $display("FAIL sat_preload got total=%0d sat=%b exp 990/0", total, sat);
    end
    step_option = 4'b1000; tick(1);
    vectors++;
    if (total !== 10'd999 || sat !== 1'b1 || add_pulse !== 1'b1) begin
      fails++; $display("FAIL sat_clip got total=%0d sat=%b pulse=%b exp 999/1/1", total, sat, add_pulse);
    end
    step_option = 4'b0000; tick(1);
    step_option = 4'b0001; tick(1);
    vectors++;
    if (total !== 10'd999 || add_pulse !== 1'b1 || {bh, bt, bo} !== 12'h999) begin
      fails++; $display("FAIL sat_at_max got total=%0d pulse=%b exp 999/1", total, add_pulse);
    end
    step_option = 4'b0000; tick(1);
  endtask

  task automatic test_freeze();
    clear_main();
    press(4'b0100);
    pulses = 0;
    hold_option = 3'b001; tick(1);
    step_option = 4'b0100; tick(3);
    vectors++;
    if (total !== 10'd10 || pulses !== 0) begin
      fails++; $display("FAIL freeze_press got total=%0d pulses=%0d exp 10/0", total, pulses);
    end
    hold_option = 3'b000; tick(3);
    vectors++;
    if (total !== 10'd10 || pulses !== 0) begin
      fails++; $display("FAIL freeze_release_held got total=%0d pulses=%0d exp 10/0", total, pulses);
    end
    step_option = 4'b0000; tick(1);
    press(4'b0100);
    vectors++;
    if (total !== 10'd20 || pulses !== 1) begin
      fails++; $display("FAIL freeze_repress got total=%0d pulses=%0d exp 20/1", total, pulses);
    end
    hold_option = 3'b101; step_option = 4'b0001; tick(1);
    vectors++;
    if (total !== 10'd20 || add_pulse !== 1'b0) begin
      fails++; $display("FAIL freeze_alias got total=%0d pulse=%b exp 20/0", total, add_pulse);
    end
    hold_option = 3'b011; tick(1);
    vectors++;
    if (total !== 10'd0) begin fails++; $display("FAIL clear_alias got=%0d exp=0", total); end
    hold_option = 3'b000; step_option = 4'b0000; tick(1);
  endtask

  task automatic test_clear();
    step2 = 4'b0000; hold2 = 3'b000;
    rst2 = 1'b1; tick(1);
    rst2 = 1'b0; tick(1);
    press2(4'b1000); press2(4'b0100); press2(4'b0010);
    vectors++;
    if (total2 !== 6'd40 || sat2 !== 1'b0) begin
      fails++; $display("FAIL clr_setup got total=%0d sat=%b exp 40/0", total2, sat2);
    end
    press2(4'b0001);
    vectors++;
    if (total2 !== 6'd40 || sat2 !== 1'b1 || {bt2, bo2} !== 8'h40) begin
      fails++; $display("FAIL clr_sat got total=%0d sat=%b exp 40/1", total2, sat2);
    end
    pulses2 = 0;
    hold2 = 3'b010; step2 = 4'b0001; tick(1);
    vectors++;
    if (total2 !== 6'd0 || sat2 !== 1'b0 || add_pulse2 !== 1'b0) begin
      fails++; $display("FAIL clr_same_edge got total=%0d sat=%b pulse=%b exp 0/0/0", total2, sat2, add_pulse2);
    end
    hold2 = 3'b000; tick(2);
    step2 = 4'b0000; tick(1);
    vectors++;
    if (total2 !== 6'd0 || pulses2 !== 0) begin
      fails++; $display("FAIL clr_held got total=%0d pulses=%0d exp 0/0", total2, pulses2);
    end
    press2(4'b0010);
    vectors++;
    if (total2 !== 6'd5 || pulses2 !== 1) begin
      fails++; $display("FAIL clr_repress got total=%0d pulses=%0d exp 5/1", total2, pulses2);
    end
  endtask

  task automatic test_reset_held();
    press(4'b0010);
    pulses = 0;
    step_option = 4'b0001;
    rst = 1'b1; tick(2);
    vectors++;
    if (total !== 10'd0 || sat !== 1'b0) begin
      fails++; $display("FAIL rst_held_assert got total=%0d sat=%b exp 0/0", total, sat);
    end
    rst = 1'b0; tick(3);
    vectors++;
    if (total !== 10'd0 || pulses !== 0) begin
      fails++; $display("FAIL rst_held_release got total=%0d pulses=%0d exp 0/0", total, pulses);
    end
    step_option = 4'b0000; tick(1);
    press(4'b0001);
    vectors++;
    if (total !== 10'd1 || pulses !== 1) begin
      fails++; $display("FAIL rst_held_repress got total=%0d pulses=%0d exp 1/1", total, pulses);
    end
  endtask

  initial begin
    rst = 1'b1; step_option = 4'b0000; hold_option = 3'b000;
    rst2 = 1'b1; step2 = 4'b0000; hold2 = 3'b000;
    test_reset();
    test_single();
    test_sequence();
    test_priority();
    test_back_to_back();
    test_saturation();
    test_freeze();
    test_clear();
    test_reset_held();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule

// File: doc/coin_tally.md
COIN_TALLY -- requirements
Module: coin_tally

Interface
REQ-001 Parameter VAL_U, default 1, credit for step_option code 4'b0001.
REQ-002 Parameter VAL_L, default 5, credit for step_option code 4'b0010.
REQ-003 Parameter VAL_R, default 10, credit for step_option code 4'b0100.
REQ-004 Parameter VAL_D, default 25, credit for step_option code 4'b1000.
REQ-005 Parameter MAX_TOTAL, default 999, saturation ceiling of total.
REQ-006 Parameter TOTAL_W, default 10, width of total; SHALL satisfy 2^TOTAL_W > MAX_TOTAL.
REQ-007 clk  input  1  single system clock; all state updates on its rising edge.
REQ-008 rst  input  1  synchronous, active-high reset.
REQ-009 step_option  input  4  debounced coin-button code: 0000 = none, else one-hot.
REQ-010 hold_option  input  3  debounced switch code: 000 = run, 001 = freeze, 010 = clear.
REQ-011 total  output  TOTAL_W  registered accumulated credit, binary.
REQ-012 bcd_hundreds, bcd_tens, bcd_ones  output  4 each  BCD digits of total, combinational from the registered total.
REQ-013 add_pulse  output  1  registered, high for exactly one cycle after each applied credit.
REQ-014 sat  output  1  registered sticky flag: a credit was clipped at MAX_TOTAL.

Function
REQ-015 FSM states: IDLE (armed), WAIT_RELEASE (press consumed), HOLD (frozen or clearing).
REQ-016 hold_option decode: bit1 set = clear; else bit0 set = freeze; else run; codes other than 000/001/010 are decoded by this rule.
REQ-017 In any state, clear or freeze -> next state HOLD; clear additionally sets total=0 and sat=0 on every cycle it is asserted.
REQ-018 HOLD with run: step_option==0000 -> IDLE; otherwise -> WAIT_RELEASE, with no credit.
REQ-019 IDLE with run and step_option != 0000: total updated at that same edge, add_pulse=1 next cycle, -> WAIT_RELEASE.
REQ-020 Credit value is selected by the lowest set bit of step_option (U>L>R>D priority); non-one-hot codes credit exactly one value.
REQ-021 WAIT_RELEASE: no credit regardless of step_option changes; step_option==0000 -> IDLE.
REQ-022 Exactly one credit per press; a press held across any number of cycles or code changes credits once.
REQ-023 Sum is computed at TOTAL_W+6 bits; if total+value > MAX_TOTAL then total=MAX_TOTAL and sat=1, else total=total+value.
REQ-024 At total==MAX_TOTAL a further press still produces add_pulse, leaves total unchanged, and sets sat.
REQ-025 Latency: press sampled at edge N -> total valid after edge N, add_pulse high between edges N and N+1.
REQ-026 Freeze/clear asserted on the same edge as a new press: hold wins, no credit, add_pulse=0.

Reset
REQ-027 rst at an edge: total=0, sat=0, add_pulse=0, state=HOLD; rst overrides all other inputs.
REQ-028 After rst release the HOLD exit rule applies, so a button held through reset does not credit.

Structure
REQ-029 Shared package coin_pkg holds the FSM state encoding, the default coin values, MAX_TOTAL, and the hold_option/step_option code constants, shared with button_debouncer consumers.
REQ-030 Sub-module bin_to_bcd (combinational, TOTAL_W in, three BCD digits out) performs the digit conversion; coin_tally instantiates it once.

Verification
REQ-031 rst 2 cycles, then step_option=0001 held 5 cycles then 0000 -> total=1, bcd_ones=1, exactly one add_pulse.
REQ-032 Presses L, R, D, D in sequence with release gaps -> total=65 (bcd 0/6/5), four add_pulses, sat=0.
REQ-033 Preload total=990 via presses, press D -> total=999, sat=1, add_pulse=1; further U press -> total stays 999.
REQ-034 hold_option=001, press R -> total unchanged, no add_pulse; release hold while R still held -> no credit until release and re-press.
REQ-035 total=40, sat=1, hold_option=010 for 1 cycle -> total=0, sat=0; same-edge press with clear gives no credit.
REQ-036 step_option=0001 held through rst assertion and deassertion -> total=0, no add_pulse until release and re-press.
